adder_checker: RTL and testbench
================================

ADDER_CHECKER -- requirements
Module: adder_checker

Interface
REQ-001 Parameter: WIDTH, default 4, operand/sum width in bits.
REQ-002 Parameter: THRESH, default 3, consecutive mismatches needed to enter FAULT; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: a, b  input  WIDTH each  operands as presented to the checked adder.
REQ-006 Port: cin  input  1  carry-in as presented to the checked adder.
REQ-007 Port: valid  input  1  a/b/cin qualify a new operation this cycle.
REQ-008 Port: s  input  WIDTH  registered sum from the checked adder.
REQ-009 Port: cout  input  1  registered carry-out from the checked adder.
REQ-010 Port: clear  input  1  clears err_sticky, err_count and FAULT state.
REQ-011 Port: chk_valid  output  1  a check result is presented this cycle.
REQ-012 Port: err  output  1  current check mismatched; qualified by chk_valid.
REQ-013 Port: err_sticky  output  1  any mismatch since last reset/clear.
REQ-014 Port: err_count  output  8  saturating total mismatch count.
REQ-015 Port: fault  output  1  high while FSM is in FAULT.

Function
REQ-016 Stage 1 SHALL register a, b, cin, valid at edge k.
REQ-017 At edge k+1, if stored valid=1, the block SHALL evaluate the (WIDTH+1)-bit value {cout,s} - a0 - cin0 (modulo 2^(WIDTH+1)) and flag a mismatch when it differs from zero-extended b0.
REQ-018 chk_valid and err SHALL be registered: both are visible in the cycle after edge k+1, i.e. two edges after operands are sampled.
REQ-019 chk_valid=0 SHALL force err=0; back-to-back valid SHALL yield one check per cycle with no bubbles.
REQ-020 err_count SHALL increment by 1 per mismatch and saturate at 8'hFF (no wrap).
REQ-021 FSM states: OK (no recent mismatch), SUSPECT (1..THRESH-1 consecutive mismatches), FAULT.
REQ-022 OK->SUSPECT on mismatch; SUSPECT->OK on a passing check; SUSPECT->FAULT when consecutive-mismatch count reaches THRESH; THRESH=1 SHALL go OK->FAULT directly.
REQ-023 Cycles with chk_valid=0 SHALL not reset or advance the consecutive-mismatch count.
REQ-024 FAULT SHALL be left only by clear or rst; passing checks in FAULT SHALL not exit it.
REQ-025 fault SHALL be 1 exactly when the FSM is in FAULT, registered.
REQ-026 clear=1 SHALL take priority over a simultaneous mismatch: that mismatch is reported on err but not counted, sticky and FSM go to reset values.
REQ-027 Full-range overflow (a=b=all ones, cin=1) SHALL check correctly with cout=1.

Reset
REQ-028 rst=1 at an edge SHALL set chk_valid=0, err=0, err_sticky=0, err_count=0, fault=0, FSM=OK, stage-1 valid=0.
REQ-029 rst mid-operation SHALL discard the in-flight stage-1 operation; no check is reported for it.
REQ-030 rst SHALL take priority over clear and valid.

Configuration
REQ-031 Macro CHECKER_PARITY_EN: when defined, input port s_par (1 bit, even parity of s from the adder, same timing as s) SHALL exist and a parity mismatch on a valid check SHALL be treated as a mismatch identical to REQ-017.
REQ-032 When CHECKER_PARITY_EN is undefined, port s_par SHALL be absent and only the arithmetic check applies.

Verification
REQ-033 a=3,b=5,cin=1,valid=1; next cycle s=9,cout=0 -> chk_valid=1, err=0, err_count=0, fault=0.
REQ-034 Same operands, s=8 injected -> err=1, err_sticky=1, err_count=1, FSM=SUSPECT, fault=0.
REQ-035 Three consecutive bad checks (THRESH=3) -> fault=1 after third; then 5 good checks -> fault stays 1; clear -> fault=0, err_count=0.
REQ-036 a=F,b=F,cin=1 with s=F,cout=1 -> err=0; with cout=0 -> err=1.
REQ-037 300 consecutive mismatches -> err_count=8'hFF; clear asserted on a mismatching check -> err_count=0, err_sticky=0, err=1 that cycle.
REQ-038 With CHECKER_PARITY_EN: a=1,b=2,cin=0, s=3,cout=0, s_par=1 -> err=1; s_par=0 -> err=0.

Source files
------------

// File: rtl/adder_checker.sv
// adder_checker: concurrent checker for a registered adder.
// Operands are captured when valid is high. One edge later the registered
// {cout,s} from the checked adder is compared against a0 + b0 + cin0. The
// result is published one cycle after that on chk_valid/err. Mismatches feed
// a sticky flag, a saturating counter and an OK/SUSPECT/FAULT state machine.
// Optional feature: define CHECKER_PARITY_EN to add the s_par input (even
// parity of s). When enabled, a parity error on a valid check counts as a
// mismatch.

module adder_checker #(
    parameter int WIDTH  = 4,
    parameter int THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             valid,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
`ifdef CHECKER_PARITY_EN
    input  logic             s_par,
`endif
    input  logic             clear,
    output logic             chk_valid,
    output logic             err,
    output logic             err_sticky,
    output logic [7:0]       err_count,
    output logic             fault
);

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [3:0] THRESH_C = 4'(THRESH);

    // Even parity of a WIDTH-bit word.
    function automatic logic even_par(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic             vld_q;

    state_t           state_q, state_d;
    logic [3:0]       consec_q, consec_d;
    logic             sticky_q, sticky_d;
    logic [7:0]       count_q, count_d;
    logic             chk_valid_q;
    logic             err_q;
    logic             fault_q;

    logic [WIDTH:0]   diff_s;
    logic             arith_bad_s;
    logic             par_bad_s;
    logic             mism_s;

    // Stage 1: capture the operands of the operation under check.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            a_q   <= {WIDTH{1'b0}};
            b_q   <= {WIDTH{1'b0}};
            cin_q <= 1'b0;
        end else begin
            vld_q <= valid;
            a_q   <= a;
            b_q   <= b;
            cin_q <= cin;
        end
    end

    // Mismatch detection: the arithmetic residue must equal b0, and optionally
    // the parity of s must match.
    always_comb begin
        diff_s      = {cout, s} - {1'b0, a_q} - {{WIDTH{1'b0}}, cin_q};
        arith_bad_s = (diff_s != {1'b0, b_q});
`ifdef CHECKER_PARITY_EN
        par_bad_s   = (s_par != even_par(s));
`else
        par_bad_s   = 1'b0;
`endif
        if (vld_q) begin
            mism_s = arith_bad_s | par_bad_s;
        end else begin
            mism_s = 1'b0;
        end
    end

    // Next-state logic for the error bookkeeping and the fault FSM. Clear wins
    // over a simultaneous mismatch. Idle cycles hold all state.
    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        sticky_d = sticky_q;
        count_d  = count_q;
        if (clear) begin
            state_d  = ST_OK;
            consec_d = 4'd0;
            sticky_d = 1'b0;
            count_d  = 8'd0;
        end else if (vld_q) begin
            if (mism_s) begin
                sticky_d = 1'b1;
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                end else begin
                    count_d = count_q;
                end
                case (state_q)
                    ST_OK: begin
                        consec_d = 4'd1;
                        if (4'd1 >= THRESH_C) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_SUSPECT;
                        end
                    end
                    ST_SUSPECT: begin
                        consec_d = consec_q + 4'd1;
                        if ((consec_q + 4'd1) >= THRESH_C) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_SUSPECT;
                        end
                    end
                    ST_FAULT: begin
                        state_d = ST_FAULT;
                    end
                    default: begin
                        state_d  = ST_OK;
                        consec_d = 4'd0;
                    end
                endcase
            end else begin
                case (state_q)
                    ST_OK: begin
                        state_d  = ST_OK;
                        consec_d = 4'd0;
                    end
                    ST_SUSPECT: begin
                        state_d  = ST_OK;
                        consec_d = 4'd0;
                    end
                    ST_FAULT: begin
                        state_d = ST_FAULT;
                    end
                    default: begin
                        state_d  = ST_OK;
                        consec_d = 4'd0;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OK;
            consec_q    <= 4'd0;
            sticky_q    <= 1'b0;
            count_q     <= 8'd0;
            chk_valid_q <= 1'b0;
            err_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            consec_q    <= consec_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
            chk_valid_q <= vld_q;
            err_q       <= mism_s;
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign chk_valid  = chk_valid_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign err_count  = count_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_adder_checker.sv
// Self-checking bench for adder_checker (WIDTH=4, THRESH=3). Each step drives
// a new operation together with the adder result for the previous one. A
// behavioural model built from integer sums predicts every output.
`timescale 1ns/1ps

module tb_adder_checker;

    localparam int W  = 4;
    localparam int TH = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b, s;
    logic         cin, valid, cout, clear;
`ifdef CHECKER_PARITY_EN
    logic         s_par;
`endif
    logic         chk_valid, err, err_sticky, fault;
    logic [7:0]   err_count;

    int tests = 0;
    int fails = 0;

    // previous operation (what the DUT will check next)
    logic         p_v = 1'b0;
    logic [W-1:0] p_a = '0, p_b = '0;
    logic         p_c = 1'b0;
    int           par_flip = 0;

    // model state
    int m_sticky = 0, m_count = 0, m_consec = 0, m_fault = 0;
    int e_chk = 0, e_err = 0;

    adder_checker #(.WIDTH(W), .THRESH(TH)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .valid(valid),
        .s(s), .cout(cout),
`ifdef CHECKER_PARITY_EN
        .s_par(s_par),
`endif
        .clear(clear), .chk_valid(chk_valid), .err(err),
        .err_sticky(err_sticky), .err_count(err_count), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] good_res();
        int sum;
        sum = int'(p_a) + int'(p_b) + int'(p_c);
        return (W+1)'(sum);
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".chk_valid"}, int'(chk_valid), e_chk);
        check({tag, ".err"},       int'(err),       e_err);
        check({tag, ".sticky"},    int'(err_sticky), m_sticky);
        check({tag, ".count"},     int'(err_count), m_count);
        check({tag, ".fault"},     int'(fault),     m_fault);
    endtask

    // One cycle: new operation (nv,na,nb,nc) plus result r = {cout,s} for prev op.
    task automatic step(input logic nv, input logic [W-1:0] na, input logic [W-1:0] nb,
                        input logic nc, input logic [W:0] r, input logic clr,
                        input string tag);
        int mism;
        @(negedge clk);
        valid = nv; a = na; b = nb; cin = nc;
        s = r[W-1:0]; cout = r[W]; clear = clr;
`ifdef CHECKER_PARITY_EN
        s_par = (^r[W-1:0]) ^ logic'(par_flip);
`endif
        @(posedge clk); #1;
        mism = (p_v && (int'(r) != int'(p_a) + int'(p_b) + int'(p_c))) ? 1 : 0;
`ifdef CHECKER_PARITY_EN
        if (p_v && par_flip != 0) mism = 1;
`endif
        e_chk = p_v ? 1 : 0;
        e_err = mism;
        if (clr) begin
            m_sticky = 0; m_count = 0; m_consec = 0; m_fault = 0;
        end else if (p_v) begin
            if (mism != 0) begin
                m_sticky = 1;
                if (m_count < 255) m_count++;
                m_consec++;
                if (m_consec >= TH) m_fault = 1;
            end else if (m_fault == 0) begin
                m_consec = 0;
            end
        end
        p_v = nv; p_a = na; p_b = nb; p_c = nc;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        m_sticky = 0; m_count = 0; m_consec = 0; m_fault = 0;
        e_chk = 0; e_err = 0; p_v = 1'b0;
        check_all(tag);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0; clear = 1'b0;
    endtask

    initial begin
        logic [W:0] r;
        logic       nv, clr;
        rst = 1'b1; a = '0; b = '0; s = '0; cin = 1'b0; valid = 1'b0;
        cout = 1'b0; clear = 1'b0;
`ifdef CHECKER_PARITY_EN
        s_par = 1'b0;
`endif
        repeat (2) @(posedge clk);
        do_reset("reset");

        // basic pass: 3+5+1 = 9
        step(1'b1, 4'd3, 4'd5, 1'b1, 5'd0, 1'b0, "op1");
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd9, 1'b0, "good9");
        check("good9.err_const", int'(err), 0);
        // single mismatch then three in a row
        step(1'b1, 4'd3, 4'd5, 1'b1, 5'd0, 1'b0, "op2");
        step(1'b1, 4'd3, 4'd5, 1'b1, 5'd8, 1'b0, "bad1");
        check("bad1.count_const", int'(err_count), 1);
        check("bad1.fault_const", int'(fault), 0);
        step(1'b1, 4'd3, 4'd5, 1'b1, 5'd8, 1'b0, "bad2");
        check("bad2.fault_const", int'(fault), 0);
        step(1'b1, 4'd3, 4'd5, 1'b1, 5'd8, 1'b0, "bad3");
        check("bad3.fault_const", int'(fault), 1);
        for (int i = 0; i < 4; i++) step(1'b1, 4'd3, 4'd5, 1'b1, 5'd9, 1'b0, "fault_good");
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd9, 1'b0, "fault_good5");
        check("fault_hold", int'(fault), 1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b1, "clear");
        check("clear.fault_const", int'(fault), 0);

        // suspect returns to OK on pass, idle cycles do not reset the run
        step(1'b1, 4'd1, 4'd1, 1'b0, 5'd0, 1'b0, "s_op");
        step(1'b1, 4'd1, 4'd1, 1'b0, 5'd3, 1'b0, "s_bad");
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd2, 1'b0, "s_good");
        step(1'b1, 4'd2, 4'd2, 1'b0, 5'd0, 1'b0, "g_op");
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd5, 1'b0, "g_bad");
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd5, 1'b0, "idle");
        step(1'b1, 4'd2, 4'd2, 1'b0, 5'd0, 1'b0, "g_op2");
        step(1'b1, 4'd2, 4'd2, 1'b0, 5'd5, 1'b0, "g_bad2");
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd5, 1'b0, "g_bad3");
        check("idle_keeps_run", int'(fault), 1);

        // full-range overflow
        do_reset("reset2");
        step(1'b1, 4'hF, 4'hF, 1'b1, 5'd0, 1'b0, "ovf_op");
        step(1'b1, 4'hF, 4'hF, 1'b1, 5'h1F, 1'b0, "ovf_good");
        check("ovf_good.err_const", int'(err), 0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'h0F, 1'b0, "ovf_bad");
        check("ovf_bad.err_const", int'(err), 1);

        // saturation then clear on a mismatching check
        for (int i = 0; i < 300; i++) begin
            r = good_res() ^ 5'd1;
            step(1'b1, 4'(i), 4'(i + 3), 1'(i), r, 1'b0, "sat_loop");
        end
        check("sat.count_const", int'(err_count), 255);
        r = good_res() ^ 5'd2;
        step(1'b0, 4'd0, 4'd0, 1'b0, r, 1'b1, "clr_on_bad");
        check("clr_on_bad.err_const", int'(err), 1);
        check("clr_on_bad.count_const", int'(err_count), 0);

        // reset discards in-flight operation
        step(1'b1, 4'd7, 4'd7, 1'b0, 5'd0, 1'b0, "inflight");
        do_reset("reset_mid");
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd3, 1'b0, "after_rst");
        check("after_rst.chk_const", int'(chk_valid), 0);

`ifdef CHECKER_PARITY_EN
        step(1'b1, 4'd1, 4'd2, 1'b0, 5'd0, 1'b0, "par_op");
        par_flip = 1;
        step(1'b1, 4'd1, 4'd2, 1'b0, 5'd3, 1'b0, "par_bad");
        check("par_bad.err_const", int'(err), 1);
        par_flip = 0;
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd3, 1'b0, "par_good");
        check("par_good.err_const", int'(err), 0);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            nv  = ($urandom_range(0, 3) != 0);
            r   = good_res();
            if ($urandom_range(0, 3) == 0) r = r ^ (W+1)'($urandom_range(1, 31));
            clr = ($urandom_range(0, 29) == 0);
`ifdef CHECKER_PARITY_EN
            par_flip = ($urandom_range(0, 9) == 0) ? 1 : 0;
`endif
            step(nv, 4'($urandom), 4'($urandom), 1'($urandom), r, clr, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
